// File: rtl/inv_pkg.sv
// inv_pkg: shared constants and helpers for inv_unit.
package inv_pkg;
  localparam int INV_DEFAULT_WIDTH = 4;
  function automatic int inv_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += 32'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/inv_unit_if.sv
// inv_unit_if: data/result bundle for inv_unit; par exists only with INV_UNIT_PARITY_EN.
interface inv_unit_if
  import inv_pkg::*;
#(
  parameter int WIDTH = INV_DEFAULT_WIDTH,
  parameter int CNT_W = inv_cnt_w(WIDTH)
);
  logic [WIDTH-1:0] d;
  logic             en;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_reg;
  logic             q_chg;
  logic [CNT_W-1:0] ones;
`ifdef INV_UNIT_PARITY_EN
  logic             par;
  modport master (output d, en, input q, q_reg, q_chg, ones, par);
  modport slave  (input d, en, output q, q_reg, q_chg, ones, par);
`else
  modport master (output d, en, input q, q_reg, q_chg, ones);
  modport slave  (input d, en, output q, q_reg, q_chg, ones);
`endif
endinterface

// File: rtl/inv_popcount.sv
// inv_popcount: combinational count of set bits in vec.
module inv_popcount
  import inv_pkg::*;
#(
  parameter int WIDTH = INV_DEFAULT_WIDTH,
  parameter int CNT_W = inv_cnt_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CNT_W-1:0] count
);
  assign count = CNT_W'(popcount(32'(vec)));
endmodule

// File: rtl/inv_unit.sv
// inv_unit: bitwise inverter with registered copy, change pulse and ones-count.
// Define INV_UNIT_PARITY_EN to add the registered parity output par.
module inv_unit
  import inv_pkg::*;
#(
  parameter int WIDTH = INV_DEFAULT_WIDTH
) (
  input logic      clk,
  input logic      rst,
  inv_unit_if.slave bus
);
  localparam int CNT_W = inv_cnt_w(WIDTH);
  logic [WIDTH-1:0] q_inv;
  logic [WIDTH-1:0] q_reg_d, q_reg_q;
  logic             q_chg_d, q_chg_q;
  assign q_inv = ~bus.d;
  always_comb begin
    q_reg_d = bus.en ? q_inv : q_reg_q;
    q_chg_d = bus.en && (q_inv != q_reg_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg_q <= '0;
      q_chg_q <= 1'b0;
    end else begin
      q_reg_q <= q_reg_d;
      q_chg_q <= q_chg_d;
    end
  end
  inv_popcount #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_pop (
    .vec   (q_inv),
    .count (bus.ones)
  );
  assign bus.q     = q_inv;
  assign bus.q_reg = q_reg_q;
  assign bus.q_chg = q_chg_q;
`ifdef INV_UNIT_PARITY_EN
  logic par_d, par_q;
  always_comb par_d = bus.en ? ^q_inv : par_q;
  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
  assign bus.par = par_q;
`endif
endmodule

// File: tb/tb_inv_unit.sv
// tb_inv_unit: directed checks of inv_unit at WIDTH=4.
module tb_inv_unit;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  inv_unit_if #(.WIDTH(4)) bus ();
  inv_unit #(.WIDTH(4)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  logic [3:0] sw_d [6] = '{4'b1111, 4'b0000, 4'b1100, 4'b0011, 4'b1010, 4'b1111};
  logic [3:0] sw_q [6] = '{4'b0000, 4'b1111, 4'b0011, 4'b1100, 4'b0101, 4'b0000};
  int         sw_n [6] = '{0, 4, 2, 2, 2, 0};
  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.d = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      bus.d = sw_d[i];
      #1;
      chk($sformatf("comb_q%0d", i), 32'(bus.q), 32'(sw_q[i]));
      chk($sformatf("comb_ones%0d", i), 32'(bus.ones), 32'(sw_n[i]));
    end
    bus.d = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_q_reg", 32'(bus.q_reg), 32'h0);
      chk("rst_q_chg", 32'(bus.q_chg), 32'h0);
      chk("rst_q", 32'(bus.q), 32'hA);
    end
    rst = 1'b0;
    bus.en = 1'b1;
    bus.d = 4'b1100;
    tick();
    chk("load_q_reg", 32'(bus.q_reg), 32'h3);
    chk("load_q_chg", 32'(bus.q_chg), 32'h1);
    bus.en = 1'b0;
    bus.d = 4'b0000;
    #1;
    chk("hold_q_comb", 32'(bus.q), 32'hF);
    chk("hold_ones", 32'(bus.ones), 32'h4);
    tick();
    chk("hold_q_reg", 32'(bus.q_reg), 32'h3);
    chk("hold_q_chg", 32'(bus.q_chg), 32'h0);
    bus.en = 1'b1;
    bus.d = 4'b1100;
    tick();
    chk("same_q_reg", 32'(bus.q_reg), 32'h3);
    chk("same_q_chg", 32'(bus.q_chg), 32'h0);
    bus.d = 4'b1111;
    tick();
    chk("diff_q_reg", 32'(bus.q_reg), 32'h0);
    chk("diff_q_chg", 32'(bus.q_chg), 32'h1);
    bus.en = 1'b0;
    tick();
    chk("pulse_end", 32'(bus.q_chg), 32'h0);
    rst = 1'b1;
    bus.en = 1'b1;
    bus.d = 4'b0000;
    tick();
    chk("prio_q_reg", 32'(bus.q_reg), 32'h0);
    chk("prio_q_chg", 32'(bus.q_chg), 32'h0);
    rst = 1'b0;
    bus.d = 4'b1111;
    tick();
    chk("first_q_reg", 32'(bus.q_reg), 32'h0);
    chk("first_q_chg", 32'(bus.q_chg), 32'h0);
    bus.d = 4'b0110;
    tick();
    chk("mid_q_reg", 32'(bus.q_reg), 32'h9);
    chk("mid_q_chg", 32'(bus.q_chg), 32'h1);
`ifdef INV_UNIT_PARITY_EN
    bus.d = 4'b1000;
    tick();
    chk("par_q_reg1", 32'(bus.q_reg), 32'h7);
    chk("par1", 32'(bus.par), 32'h1);
    bus.en = 1'b0;
    bus.d = 4'b1010;
    tick();
    chk("par_hold", 32'(bus.par), 32'h1);
    bus.en = 1'b1;
    tick();
    chk("par_q_reg2", 32'(bus.q_reg), 32'h5);
    chk("par2", 32'(bus.par), 32'h0);
    bus.d = 4'b1110;
    tick();
    chk("par3", 32'(bus.par), 32'h1);
    rst = 1'b1;
    tick();
    chk("par_rst", 32'(bus.par), 32'h0);
    rst = 1'b0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inv_unit.md
Name: inv_unit

Overview:
- Parameterised bitwise inverter for small data buses.
- Primary output q is the purely combinational complement of input d.
- A registered copy of the complement, a change-detect pulse and a ones-count are provided for downstream pipelined consumers.
- Sits as a leaf utility block between a data source and any logic needing the active-low form of a bus.

Parameters:
- WIDTH, 4, bit width of d, q and q_reg (legal range 1..32).
- CNT_W, $clog2(WIDTH+1), width of the ones-count output (derived; do not override).

Ports:
- clk  input  1  single clock; all registers update on its rising edge.
- rst  input  1  synchronous, active-high reset.
- d  input  WIDTH  data to invert.
- en  input  1  load enable for the registered path.
- q  output  WIDTH  combinational complement, q = ~d.
- q_reg  output  WIDTH  registered complement of d.
- q_chg  output  1  one-cycle pulse when q_reg changed value on the last load.
- ones  output  CNT_W  number of 1 bits in q (combinational).

Behaviour:
- q = ~d bit for bit, zero latency, independent of clk, rst and en. It is valid during reset.
- ones = popcount(q) = WIDTH − popcount(d), combinational.
- Registered path, evaluated on each rising clk edge:
  - rst=1: q_reg <= all zeros, q_chg <= 0. rst has priority over en.
  - rst=0, en=1: q_reg <= ~d. q_chg <= 1 if (~d) != old q_reg, else 0.
  - rst=0, en=0: q_reg holds and q_chg <= 0.
- Latency of q_reg: one cycle from d sampled with en=1.
- q_chg is never asserted for two consecutive cycles unless a new load with a differing value occurs.
- Reset mid-stream: q_reg clears on the same edge as rst. The first load after reset compares against zero, so d = all-ones gives q_chg=0.
- Boundary values: d all-zeros gives q all-ones and ones=WIDTH. d all-ones gives q=0 and ones=0.
- Arithmetic: ones is an unsigned count, never wraps; CNT_W is sized to hold WIDTH.
- No X propagation from en: if en is unknown, q_reg is treated as undefined. The bench shall drive en to a known value.

Optional Feature:
- Macro: INV_UNIT_PARITY_EN.
- Defined: adds output port par (1 bit), the registered XOR-reduction of ~d.
  - Updates under the same rst/en rules as q_reg.
  - Resets to 0; holds when en=0.
- Undefined: port par and its flop do not exist. All other behaviour is identical.

Decomposition:
- Package inv_pkg:
  - constant INV_DEFAULT_WIDTH = 4;
  - function inv_cnt_w(width) returning $clog2(width+1);
  - a popcount function usable in constant and runtime contexts.
- One sub-module is natural: inv_popcount (parameter WIDTH, input vec, output count), instantiated for ones.
- Everything else stays in inv_unit.

Test Plan:
- Combinational sweep, WIDTH=4, no clock dependence, checked 1 ns after each change:
  - d=1111 -> q=0000, ones=0
  - d=0000 -> q=1111, ones=4
  - d=1100 -> q=0011, ones=2
  - d=0011 -> q=1100, ones=2
  - d=1010 -> q=0101, ones=2
  - d=1111 -> q=0000, ones=0
- Reset: rst=1 for 2 cycles with d=0101 -> q_reg=0000, q_chg=0; q=1010 throughout.
- Load/hold: en=1, d=1100 -> next cycle q_reg=0011, q_chg=1. Then en=0, d=0000 -> q_reg stays 0011, q_chg=0, while q=1111 immediately.
- No-change load: q_reg=0011, en=1, d=1100 again -> q_reg=0011, q_chg=0. Then d=1111 -> q_reg=0000, q_chg=1.
- Priority: rst=1 and en=1 on the same edge with d=0000 -> q_reg=0000 (not 1111), q_chg=0.
- With INV_UNIT_PARITY_EN defined: en=1, d=1000 -> q_reg=0111, par=1. Then d=1010 -> q_reg=0101, par=0. After rst -> par=0.
